// File: rtl/tmds_timing_ctrl.sv
// Video timing controller for a three-channel TMDS transmitter.
// Generates h/v timing, encoder disp_ena/control, and pulls pixels from an
// upstream valid/ready source, flagging any active pixel that was missed.
module tmds_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] rgb_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        clr_underflow,
    output logic        disp_ena,
    output logic [1:0]  ctrl0,
    output logic [1:0]  ctrl1,
    output logic [1:0]  ctrl2,
    output logic [7:0]  d_b,
    output logic [7:0]  d_g,
    output logic [7:0]  d_r,
    output logic        frame_start,
    output logic        line_start,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        underflow
);

    // Region boundaries on each axis: active, front porch, sync, back porch.
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] H_SS   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SE   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] V_SS   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SE   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [11:0] h_cnt_reg, h_cnt_next;
    logic [11:0] v_cnt_reg, v_cnt_next;
    logic        active, hsync, vsync;

    logic        disp_ena_reg, frame_start_reg, line_start_reg, underflow_reg;
    logic [1:0]  ctrl0_reg;
    logic [11:0] x_reg, y_reg;

    assign active = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
    assign hsync  = (h_cnt_reg >= H_SS) && (h_cnt_reg < H_SE);
    assign vsync  = (v_cnt_reg >= V_SS) && (v_cnt_reg < V_SE);

    // A pixel is consumed on every enabled active position, out of reset.
    assign pix_ready = active && enable && !rst;

    // Next raster position; disabled timing parks at the origin.
    always_comb begin
        h_cnt_next = h_cnt_reg;
        v_cnt_next = v_cnt_reg;
        if (!enable) begin
            h_cnt_next = 12'd0;
            v_cnt_next = 12'd0;
        end else if (h_cnt_reg == H_LAST) begin
            h_cnt_next = 12'd0;
            v_cnt_next = (v_cnt_reg == V_LAST) ? 12'd0 : v_cnt_reg + 12'd1;
        end else begin
            h_cnt_next = h_cnt_reg + 12'd1;
        end
    end

    // Raster position register.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_reg <= 12'd0;
            v_cnt_reg <= 12'd0;
        end else begin
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
        end
    end

    // Registered timing outputs, one clock behind the raster position.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            disp_ena_reg    <= 1'b0;
            ctrl0_reg       <= {~VS_POL, ~HS_POL};
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
            x_reg           <= 12'd0;
            y_reg           <= 12'd0;
        end else begin
            disp_ena_reg    <= active;
            ctrl0_reg       <= {vsync ? VS_POL : ~VS_POL, hsync ? HS_POL : ~HS_POL};
            frame_start_reg <= (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);
            line_start_reg  <= (h_cnt_reg == 12'd0);
            x_reg           <= h_cnt_reg;
            y_reg           <= v_cnt_reg;
        end
    end

    // Sticky underflow: a missed active pixel wins over a clear; held while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_reg <= 1'b0;
        end else if (enable) begin
            if (active && !pix_valid) begin
                underflow_reg <= 1'b1;
            end else if (clr_underflow) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    // Per-channel data registers: channel 0 = blue, 1 = green, 2 = red.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_ch
            logic [7:0] d_reg;
            // Transferred pixel byte on active beats, zero on misses and blanking.
            always_ff @(posedge clk) begin
                if (rst || !enable) begin
                    d_reg <= 8'd0;
                end else begin
                    d_reg <= (active && pix_valid) ? rgb_in[gi*8 +: 8] : 8'd0;
                end
            end
        end
    endgenerate

    assign d_b         = gen_ch[0].d_reg;
    assign d_g         = gen_ch[1].d_reg;
    assign d_r         = gen_ch[2].d_reg;
    assign disp_ena    = disp_ena_reg;
    assign ctrl0       = ctrl0_reg;
    assign ctrl1       = 2'b00;
    assign ctrl2       = 2'b00;
    assign frame_start = frame_start_reg;
    assign line_start  = line_start_reg;
    assign x           = x_reg;
    assign y           = y_reg;
    assign underflow   = underflow_reg;

endmodule

// File: tb/tb_tmds_timing_ctrl.sv
// Directed bench for tmds_timing_ctrl on an 8x6 raster (48 clocks per frame).
module tb_tmds_timing_ctrl;

    logic        clk = 1'b0;
    logic        rst, enable, pix_valid, clr_underflow;
    logic [23:0] rgb_in;
    logic        pix_ready, disp_ena, frame_start, line_start, underflow;
    logic [1:0]  ctrl0, ctrl1, ctrl2;
    logic [7:0]  d_b, d_g, d_r;
    logic [11:0] x, y;

    int checks = 0;
    int failures = 0;

    // Reference raster position and underflow state.
    int   hp = 0;
    int   vp = 0;
    logic uf_m = 1'b0;

    // Per-frame tallies taken from the DUT outputs.
    int n_disp, n_hs, n_vs, n_fs;

    tmds_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .rgb_in(rgb_in),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .clr_underflow(clr_underflow), .disp_ena(disp_ena),
        .ctrl0(ctrl0), .ctrl1(ctrl1), .ctrl2(ctrl2),
        .d_b(d_b), .d_g(d_g), .d_r(d_r),
        .frame_start(frame_start), .line_start(line_start),
        .x(x), .y(y), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({disp_ena, ctrl0, ctrl1, ctrl2, frame_start, line_start,
                    x, y, d_r, d_g, d_b, underflow});
    endfunction

    task automatic clr_stats();
        n_disp = 0; n_hs = 0; n_vs = 0; n_fs = 0;
    endtask

    // One clock: drive inputs for the current position, check pix_ready,
    // clock, then compare every registered output against the reference.
    task automatic tick(input logic en, input logic rs, input logic valid, input logic clr);
        logic        act;
        logic [7:0]  b;
        logic [23:0] dexp;
        logic [63:0] exp;
        act = (hp < 4) && (vp < 3);
        b   = 8'(vp * 4 + hp + 1);
        enable = en; rst = rs; pix_valid = valid; clr_underflow = clr;
        rgb_in = {b + 8'h80, b ^ 8'h55, b};
        #1;
        chk("pix_ready", 64'(pix_ready), 64'(act && en && !rs));
        @(posedge clk);
        #1;
        if (rs) begin
            uf_m = 1'b0;
            exp  = 64'({1'b0, 2'b11, 4'b0000, 2'b00, 24'h0, 24'h0, 1'b0});
            hp = 0; vp = 0;
        end else if (!en) begin
            exp  = 64'({1'b0, 2'b11, 4'b0000, 2'b00, 24'h0, 24'h0, uf_m});
            hp = 0; vp = 0;
        end else begin
            uf_m = (act && !valid) ? 1'b1 : (clr ? 1'b0 : uf_m);
            dexp = (act && valid) ? {b + 8'h80, b ^ 8'h55, b} : 24'h0;
            exp  = 64'({act, ~(vp == 4), ~(hp == 5 || hp == 6), 4'b0000,
                        (hp == 0 && vp == 0), (hp == 0), 12'(hp), 12'(vp), dexp, uf_m});
            hp++;
            if (hp == 8) begin
                hp = 0;
                vp = (vp == 5) ? 0 : vp + 1;
            end
        end
        chk($sformatf("out h=%0d v=%0d", x, y), out_vec(), exp);
        n_disp += int'(disp_ena);
        n_hs   += int'(!ctrl0[0]);
        n_vs   += int'(!ctrl0[1]);
        n_fs   += int'(frame_start);
        $display("tick rst=%0b en=%0b v=%0b clr=%0b -> de=%0b ctrl0=%b fs=%0b ls=%0b x=%0d y=%0d rgb=%h uf=%0b",
                 rs, en, valid, clr, disp_ena, ctrl0, frame_start, line_start, x, y,
                 {d_r, d_g, d_b}, underflow);
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, "_disp"}, 64'(n_disp), 64'd12);
        chk({tag, "_hs"},   64'(n_hs),   64'd12);
        chk({tag, "_vs"},   64'(n_vs),   64'd8);
        chk({tag, "_fs"},   64'(n_fs),   64'd1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; pix_valid = 1'b1; clr_underflow = 1'b0; rgb_in = 24'h0;

        // Reset state.
        tick(1, 1, 1, 0);
        tick(1, 1, 1, 0);
        chk("reset_vals", out_vec(), 64'({1'b0, 2'b11, 4'b0000, 2'b00, 24'h0, 24'h0, 1'b0}));

        // Active window / hsync / vsync over one clean frame.
        clr_stats();
        for (int i = 0; i < 48; i++) begin
            tick(1, 0, 1, 0);
            if (i == 0) chk("first_fs", 64'({frame_start, line_start, d_b}), 64'({2'b11, 8'h01}));
            if (i == 5) chk("hs_low_x5", 64'({ctrl0, x}), 64'({2'b10, 12'd5}));
        end
        chk_frame("f1");

        // Underflow: miss at (2,1); miss with clear at (1,2); lone clear at (2,4).
        clr_stats();
        for (int i = 0; i < 48; i++) begin
            tick(1, 0, !(i == 10 || i == 17), (i == 17 || i == 34));
            if (i == 10) chk("uf_beat", 64'({disp_ena, d_r, d_g, d_b, underflow}), 64'({1'b1, 24'h0, 1'b1}));
            if (i == 17) chk("uf_clr_collide", 64'(underflow), 64'd1);
            if (i == 34) chk("uf_cleared", 64'(underflow), 64'd0);
        end
        chk_frame("f2");

        // Reset mid-line at h=2, v=1.
        for (int i = 0; i < 10; i++) tick(1, 0, 1, 0);
        tick(1, 1, 1, 0);
        chk("rst_mid", out_vec(), 64'({1'b0, 2'b11, 4'b0000, 2'b00, 24'h0, 24'h0, 1'b0}));
        clr_stats();
        for (int i = 0; i < 48; i++) begin
            tick(1, 0, !(i == 1), 0);
            if (i == 0) chk("rst_fs", 64'(frame_start), 64'd1);
        end
        chk_frame("f3");

        // Enable gap mid-frame with underflow already set.
        for (int i = 0; i < 20; i++) tick(1, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 1, 0);
            if (i == 9) chk("gap_outs", 64'({pix_ready, disp_ena, ctrl0, underflow}), 64'({2'b00, 2'b11, 1'b1}));
        end
        clr_stats();
        for (int i = 0; i < 48; i++) begin
            tick(1, 0, 1, 0);
            if (i == 0) chk("reen_fs_uf", 64'({frame_start, x, y, underflow}), 64'({1'b1, 24'h0, 1'b1}));
        end
        chk_frame("f4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
